// File: rtl/gf_inv_seq_if.sv
// Operand/result handshake bundle for the sequential GF(2^m) inverter.
interface gf_inv_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] inv_b;
   logic [WIDTH-1:0] test_result;
   logic             check_ok;

   modport master (
      output in_valid, b, out_ready,
      input  in_ready, out_valid, inv_b, test_result, check_ok
   );

   modport slave (
      input  in_valid, b, out_ready,
      output in_ready, out_valid, inv_b, test_result, check_ok
   );
endinterface

// File: rtl/gf_inv_seq.sv
// Multi-cycle GF(2^WIDTH) inverse b^(2^m-2) by square-and-multiply,
// one shared field multiplier, registered self-check product.
module gf_inv_seq #(
   parameter int          WIDTH = 8,
   parameter int unsigned POLY  = 'h11B
) (
   input logic        clk,
   input logic        rst_n,
   gf_inv_seq_if.slave io
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] RED = POLY[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 2);

   typedef enum logic [2:0] {
      IDLE, SQR, MUL, CHK, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IW-1:0]    iter_q, iter_d;
   logic [WIDTH-1:0] inv_q, inv_d;
   logic [WIDTH-1:0] tr_q, tr_d;
   logic             ok_q, ok_d;
   logic [WIDTH-1:0] mx, my, prod;

   // MSB-first shift-and-add; reduction folded into each shift
   function automatic logic [WIDTH-1:0] mul(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      logic [WIDTH-1:0] p;
      p = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         p = {p[WIDTH-2:0], 1'b0} ^ (p[WIDTH-1] ? RED : '0);
         if (y[i]) p = p ^ x;
      end
      return p;
   endfunction

   always_comb begin
      mx = base_q;
      my = base_q;
      unique case (state_q)
         MUL: begin
            mx = acc_q;
            my = base_q;
         end
         CHK: begin
            mx = a_q;
            my = acc_q;
         end
         default: ;
      endcase
   end

   assign prod = mul(mx, my);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      base_d  = base_q;
      acc_d   = acc_q;
      iter_d  = iter_q;
      inv_d   = inv_q;
      tr_d    = tr_q;
      ok_d    = ok_q;
      unique case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               a_d     = io.b;
               base_d  = io.b;
               acc_d   = ONE;
               iter_d  = '0;
               state_d = SQR;
            end
         end
         SQR: begin
            base_d  = prod;
            state_d = MUL;
         end
         MUL: begin
            acc_d   = prod;
            iter_d  = iter_q + 1'b1;
            state_d = (iter_q == LAST) ? CHK : SQR;
         end
         CHK: begin
            inv_d   = acc_q;
            tr_d    = prod;
            ok_d    = ((a_q != '0) && (prod == ONE)) ||
                      ((a_q == '0) && (acc_q == '0));
            state_d = DONE;
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         base_q  <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
         inv_q   <= '0;
         tr_q    <= '0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         iter_q  <= iter_d;
         inv_q   <= inv_d;
         tr_q    <= tr_d;
         ok_q    <= ok_d;
      end
   end

   assign io.in_ready    = (state_q == IDLE);
   assign io.out_valid   = (state_q == DONE);
   assign io.inv_b       = inv_q;
   assign io.test_result = tr_q;
   assign io.check_ok    = ok_q;
endmodule

// File: doc/gf_inv_seq.md
# gf_inv_seq

Sequential, parametrised GF(2^WIDTH) multiplicative-inverse unit with valid/ready handshakes on input and output. It computes inv_b = b^(2^WIDTH − 2) with a single shared field multiplier over several cycles. It also produces a self-check product b·inv_b. It is the multi-cycle successor of the combinational 8-bit inverse feeding the AES S-box path, and WIDTH/POLY are generalised so the same block also serves small-field test configurations.

## Interface
- WIDTH, default 8: field degree m, legal range 2..16.
- POLY, default 'h11B: irreducible polynomial, WIDTH+1 bits; bit WIDTH must be 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  b is valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- b  in  WIDTH  operand; captured on the accept edge.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- inv_b  out  WIDTH  multiplicative inverse of the captured b; 0 when b = 0.
- test_result  out  WIDTH  b·inv_b mod POLY; equals 1 for nonzero b, 0 for b = 0.
- check_ok  out  1  1 when (b ≠ 0 and test_result = 1) or (b = 0 and inv_b = 0).

## Operation
- Registers:
  - a_q: captured b.
  - base_q and acc_q: WIDTH bits each.
  - iter_q: counter of ceil(log2(WIDTH)) bits.
  - state_q.
- One combinational GF multiplier mul(x, y) is shared across states. It computes the carry-less product reduced modulo POLY, and the result is always WIDTH bits.
- FSM states: IDLE, SQR, MUL, CHK, DONE.
  - IDLE: in_ready = 1. On in_valid: a_q ← b, base_q ← b, acc_q ← 1, iter_q ← 0, go to SQR.
  - SQR: base_q ← mul(base_q, base_q), go to MUL.
  - MUL: acc_q ← mul(acc_q, base_q), iter_q ← iter_q + 1. If iter_q = WIDTH − 2, go to CHK; otherwise go to SQR.
  - CHK: inv_b ← acc_q, test_result ← mul(a_q, acc_q), check_ok computed from those values, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Invariant: after k SQR/MUL pairs, acc_q = a^(2^(k+1) − 2). After WIDTH − 1 pairs, acc_q = a^(2^WIDTH − 2).
- b = 0 needs no special case. The result is naturally 0, test_result = 0 and check_ok = 1.
- inv_b, test_result and check_ok are registered. They stay stable from CHK until the next CHK.
- in_valid is ignored outside IDLE, and b is not sampled there.

## Timing
- Reset (rst_n = 0 at an edge): state_q ← IDLE; in_ready = 1 after the edge.
  - out_valid, inv_b, test_result, check_ok, a_q, base_q, acc_q and iter_q all reset to 0.
  - Reset applies in any state and aborts an operation in flight; that result is never presented.
- Latency: out_valid rises L = 2(WIDTH−1)+1 cycles after the accept edge. L = 15 for WIDTH = 8 and L = 7 for WIDTH = 4.
- in_ready is 0 from the cycle after the accept edge until the cycle after the output handshake.
- No overlap between operations:
  - Output handshake at edge E → IDLE after E.
  - Next acceptance no earlier than E+1.
  - Minimum issue interval is L+2 cycles with out_ready held high.
- Backpressure: with out_ready low, DONE holds indefinitely. out_valid and all outputs stay unchanged.
- out_valid depends only on state_q, with no combinational path from out_ready.
- in_ready depends only on state_q, with no combinational path from in_valid.

## Test plan
- WIDTH=8, POLY='h11B, out_ready=1:
  - b=01 → inv_b=01, test_result=01, check_ok=1.
  - out_valid rises exactly 15 cycles after the accept edge.
- WIDTH=8: b=02 → inv_b=8D; b=53 → inv_b=CA; b=FF → inv_b=1C. All give test_result=01 and check_ok=1.
- WIDTH=8:
  - b=00 → inv_b=00, test_result=00, check_ok=1.
  - Then sweep all 255 nonzero b; each must give test_result=01.
- Backpressure, b=53 with out_ready low for 10 cycles after out_valid:
  - out_valid, inv_b=CA and in_ready=0 are held throughout.
  - A different b pulsed with in_valid during the hold is ignored.
  - Release out_ready → handshake, then in_ready=1 on the next cycle.
- Reset mid-operation:
  - Accept b=02 and drive rst_n=0 at cycle 6. All outputs read 0 and in_ready=1 after that edge.
  - Then b=03 → inv_b=F6, with no stale result.
- WIDTH=4, POLY='h13:
  - b=2 → inv_b=9; b=F → inv_b=8; b=0 → inv_b=0.
  - Latency is 7 cycles.
